bmp_stream_sequencer: RTL

Front-end controller for the detection datapath. Consumes a raw 24-bit BMP file as a byte stream, parses and validates the header, discards header slack and row padding, and issues one pixel per handshake to the downstream detection pipeline. Each pixel carries X/Y coordinates and frame/line markers. Sits between the file/memory loader and `top`'s pixel datapath, and replaces free-running DATA/ENABLE driving with a sequenced frame.

---
 rtl/bmp_stream_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bmp_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bmp_stream_sequencer
// Description : Parses a raw 24-bit BMP byte stream, validates the header and
//               emits one coordinate-tagged pixel per downstream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_stream_sequencer #(
    parameter int MAX_WIDTH  = 1024,
    parameter int MAX_HEIGHT = 1024,
    parameter int DIM_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [7:0]       IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [23:0]      PIX_DATA,
    output logic             PIX_VALID,
    input  logic             PIX_READY,
    output logic [DIM_W-1:0] PIX_X,
    output logic [DIM_W-1:0] PIX_Y,
    output logic             PIX_SOF,
    output logic             PIX_EOL,
    output logic             PIX_EOF,
    output logic [DIM_W-1:0] IMG_WIDTH,
    output logic [DIM_W-1:0] IMG_HEIGHT,
    output logic             BUSY,
    output logic             ERROR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_SKIP   = 3'd2,
        S_PIXEL  = 3'd3,
        S_PAD    = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [DIM_W-1:0] c_one = {{(DIM_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_next;
    logic [15:0]      r_byte_cnt;
    logic [15:0]      r_sig, r_bpp;
    logic [31:0]      r_off, r_w, r_h;
    logic [1:0]       r_phase, r_pad_cnt;
    logic [7:0]       r_b, r_g;
    logic [DIM_W-1:0] r_x, r_y, r_img_w, r_img_h;
    logic             r_fin;
    logic             r_pix_valid, r_sof, r_eol, r_eof;
    logic [23:0]      r_pix_data;
    logic [DIM_W-1:0] r_pix_x, r_pix_y;

    logic             w_in_ready, w_acc, w_start, w_load;
    logic             w_hdr_last, w_hdr_bad, w_skip_last, w_x_last, w_pad_last;
    logic [1:0]       w_pad;

    assign w_start     = START && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_acc       = IN_VALID && w_in_ready;
    assign w_load      = w_acc && (r_state == S_PIXEL) && (r_phase == 2'd2);
    assign w_hdr_last  = (r_byte_cnt == 16'd53);
    assign w_skip_last = (r_byte_cnt == r_off[15:0] - 16'd1);
    assign w_x_last    = (r_x == r_img_w - c_one);
    // 24 bpp rows are padded to 4 bytes: pad = (4 - 3W mod 4) mod 4 = W mod 4
    assign w_pad       = r_img_w[1:0];
    assign w_pad_last  = (r_pad_cnt == w_pad - 2'd1);

    assign w_hdr_bad = (r_sig != 16'h4D42) || (r_off < 32'd54) || (r_off[31:16] != 16'd0) ||
                       (r_w == 32'd0) || (r_h == 32'd0) || r_w[31] || r_h[31] ||
                       (r_w > 32'(MAX_WIDTH)) || (r_h > 32'(MAX_HEIGHT)) || (r_bpp != 16'd24);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            S_IDLE, S_ERR: if (START) w_next = S_HEADER;
            S_HEADER: begin
                w_in_ready = 1'b1;
                if (w_acc && w_hdr_last)
                    w_next = w_hdr_bad ? S_ERR : ((r_off == 32'd54) ? S_PIXEL : S_SKIP);
            end
            S_SKIP: begin
                w_in_ready = 1'b1;
                if (w_acc && w_skip_last) w_next = S_PIXEL;
            end
            S_PIXEL: begin
                // B and G may be buffered while the previous pixel is stalled
                w_in_ready = !((r_phase == 2'd2) && r_pix_valid && !PIX_READY);
                if (w_load && w_x_last) begin
                    if (w_pad != 2'd0)     w_next = S_PAD;
                    else if (r_y == '0)    w_next = S_DONE;
                end
            end
            S_PAD: begin
                w_in_ready = 1'b1;
                if (w_acc && w_pad_last) w_next = r_fin ? S_DONE : S_PIXEL;
            end
            S_DONE: if (!r_pix_valid) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_byte_cnt <= '0;
            r_sig      <= '0;
            r_bpp      <= '0;
            r_off      <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_phase    <= '0;
            r_pad_cnt  <= '0;
            r_b        <= '0;
            r_g        <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_img_w    <= '0;
            r_img_h    <= '0;
            r_fin      <= 1'b0;
        end else if (w_start) begin
            r_byte_cnt <= '0;
            r_phase    <= '0;
            r_pad_cnt  <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_img_w    <= '0;
            r_img_h    <= '0;
            r_fin      <= 1'b0;
        end else if (w_acc) begin
            case (r_state)
                S_HEADER: begin
                    r_byte_cnt <= r_byte_cnt + 16'd1;
                    // Little-endian fields: shift each byte in from the top
                    if (r_byte_cnt <= 16'd1)
                        r_sig <= {IN_DATA, r_sig[15:8]};
                    if ((r_byte_cnt >= 16'd10) && (r_byte_cnt <= 16'd13))
                        r_off <= {IN_DATA, r_off[31:8]};
                    if ((r_byte_cnt >= 16'd18) && (r_byte_cnt <= 16'd21))
                        r_w <= {IN_DATA, r_w[31:8]};
                    if ((r_byte_cnt >= 16'd22) && (r_byte_cnt <= 16'd25))
                        r_h <= {IN_DATA, r_h[31:8]};
                    if ((r_byte_cnt >= 16'd28) && (r_byte_cnt <= 16'd29))
                        r_bpp <= {IN_DATA, r_bpp[15:8]};
                    if (w_hdr_last && !w_hdr_bad) begin
                        r_img_w <= r_w[DIM_W-1:0];
                        r_img_h <= r_h[DIM_W-1:0];
                        r_y     <= r_h[DIM_W-1:0] - c_one;
                    end
                end
                S_SKIP: r_byte_cnt <= r_byte_cnt + 16'd1;
                S_PIXEL: begin
                    case (r_phase)
                        2'd0: begin
                            r_b     <= IN_DATA;
                            r_phase <= 2'd1;
                        end
                        2'd1: begin
                            r_g     <= IN_DATA;
                            r_phase <= 2'd2;
                        end
                        default: begin
                            r_phase <= 2'd0;
                            if (w_x_last) begin
                                r_x <= '0;
                                if (r_y == '0) r_fin <= 1'b1;
                                else           r_y   <= r_y - c_one;
                            end else begin
                                r_x <= r_x + c_one;
                            end
                        end
                    endcase
                end
                S_PAD: r_pad_cnt <= w_pad_last ? 2'd0 : r_pad_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pix_valid <= 1'b0;
            r_pix_data  <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
        end else if (w_load) begin
            r_pix_valid <= 1'b1;
            r_pix_data  <= {IN_DATA, r_g, r_b};
            r_pix_x     <= r_x;
            r_pix_y     <= r_y;
            r_sof       <= (r_x == '0) && (r_y == r_img_h - c_one);
            r_eol       <= w_x_last;
            r_eof       <= w_x_last && (r_y == '0);
        end else if (PIX_READY) begin
            r_pix_valid <= 1'b0;
        end
    end

    assign IN_READY   = w_in_ready;
    assign PIX_VALID  = r_pix_valid;
    assign PIX_DATA   = r_pix_data;
    assign PIX_X      = r_pix_x;
    assign PIX_Y      = r_pix_y;
    assign PIX_SOF    = r_sof;
    assign PIX_EOL    = r_eol;
    assign PIX_EOF    = r_eof;
    assign IMG_WIDTH  = r_img_w;
    assign IMG_HEIGHT = r_img_h;
    assign BUSY       = (r_state != S_IDLE) && (r_state != S_ERR);
    assign ERROR      = (r_state == S_ERR);

endmodule
`default_nettype wire
